// File: rtl/fifo_pkg.sv
// Shared constants and width helpers for the flop-based status FIFO.
// Width functions are constant functions so they can size ports and parameters.
package fifo_pkg;

    localparam int DEF_DEPTH = 16;
    localparam int DEF_BITS  = 16;

    // Occupancy needs to represent 0..DEPTH inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_ptr_wrap.sv
// Modulo-DEPTH pointer register with enable; DEPTH need not be a power of two.
// The pointer returns to zero explicitly after DEPTH-1 instead of relying on overflow.
module fifo_ptr_wrap #(
    parameter int DEPTH = 16,
    parameter int PW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [PW-1:0] ptr
);

    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_flops_status.sv
// Flop-based synchronous FIFO with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow flags and registered or fall-through read data.
module fifo_flops_status
    import fifo_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int BITS     = DEF_BITS,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 1,
    parameter int FWFT     = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [BITS-1:0]               Din,
    input  logic                          push,
    input  logic                          pop,
    input  logic                          clr_err,
    output logic [BITS-1:0]               Dout,
    output logic                          pndng,
    output logic                          full,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [cnt_width(DEPTH)-1:0]   count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int CW = cnt_width(DEPTH);
    localparam int PW = ptr_width(DEPTH);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

    logic [BITS-1:0] mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            push_ok;
    logic            pop_ok;

    // Handshake: push/pop are requests sampled every rising edge; full acts as
    // the write-side not-ready and pndng as the read-side valid. A push is
    // accepted when not full or when a pop frees a slot at the same edge; a
    // pop is accepted only when data is pending. Rejected requests are
    // dropped and recorded in the sticky error flags.
    assign pop_ok  = pop & pndng;
    assign push_ok = push & (~full | pop_ok);

    assign pndng        = (count != '0);
    assign full         = (count == FULL_CNT);
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);

    fifo_ptr_wrap #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .en  (push_ok),
        .ptr (wr_ptr)
    );

    fifo_ptr_wrap #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .en  (pop_ok),
        .ptr (rd_ptr)
    );

    // Storage is deliberately not reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= Din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A new error at the same edge as clr_err keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push & ~push_ok)  overflow <= 1'b1;
            else if (clr_err)     overflow <= 1'b0;
            if (pop & ~pop_ok)    underflow <= 1'b1;
            else if (clr_err)     underflow <= 1'b0;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is shown directly; the value while empty is parked at zero.
            assign Dout = pndng ? mem[rd_ptr] : '0;
        end else begin : g_reg
            logic [BITS-1:0] dout_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dout_q <= '0;
                end else if (pop_ok) begin
                    dout_q <= mem[rd_ptr];
                end
            end

            assign Dout = dout_q;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_flops_status.sv
// Self-checking bench: registered-output FIFO (DEPTH 16, AF 14, AE 2) driven from a
// vector table, plus a fall-through DEPTH 5 instance checked against a queue model.
module tb_fifo_flops_status;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: DEPTH 16, registered output
    logic        rst0 = 1'b0;
    logic [15:0] din0 = '0;
    logic        push0 = 1'b0, pop0 = 1'b0, clr0 = 1'b0;
    logic [15:0] dout0;
    logic        pndng0, full0, af0, ae0, ov0, un0;
    logic [4:0]  count0;

    // Instance 1: DEPTH 5, fall-through output
    logic        rst1 = 1'b0;
    logic [15:0] din1 = '0;
    logic        push1 = 1'b0, pop1 = 1'b0, clr1 = 1'b0;
    logic [15:0] dout1;
    logic        pndng1, full1, af1, ae1, ov1, un1;
    logic [2:0]  count1;

    fifo_flops_status #(.DEPTH(16), .BITS(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) u_dut0 (
        .clk          (clk),
        .rst          (rst0),
        .Din          (din0),
        .push         (push0),
        .pop          (pop0),
        .clr_err      (clr0),
        .Dout         (dout0),
        .pndng        (pndng0),
        .full         (full0),
        .almost_full  (af0),
        .almost_empty (ae0),
        .count        (count0),
        .overflow     (ov0),
        .underflow    (un0)
    );

    fifo_flops_status #(.DEPTH(5), .BITS(16), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(1)) u_dut1 (
        .clk          (clk),
        .rst          (rst1),
        .Din          (din1),
        .push         (push1),
        .pop          (pop1),
        .clr_err      (clr1),
        .Dout         (dout1),
        .pndng        (pndng1),
        .full         (full1),
        .almost_full  (af1),
        .almost_empty (ae1),
        .count        (count1),
        .overflow     (ov1),
        .underflow    (un1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        push;
        logic        pop;
        logic        clr;
        logic [15:0] din;
        int          cnt;
        logic [15:0] dout;
        logic        ov;
        logic        un;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic pu, input logic po, input logic cl,
                                input logic [15:0] d, input int c,
                                input logic [15:0] dq, input logic ov, input logic un);
        vec_t v;
        v.push = pu; v.pop = po; v.clr = cl; v.din = d;
        v.cnt = c; v.dout = dq; v.ov = ov; v.un = un;
        vq.push_back(v);
    endfunction

    initial begin
        logic [15:0] mq[$];
        logic        m_ov, m_un, pu, po, p_ok, w_ok;
        int          pushes;
        logic [15:0] nxt;

        // ---------------- reset ----------------
        #1;
        rst0 = 1'b1;
        rst1 = 1'b1;
        tick();
        tick();
        check("rst_count", 32'(count0), 32'd0);
        check("rst_pndng", 32'(pndng0), 32'd0);
        check("rst_full", 32'(full0), 32'd0);
        check("rst_ae", 32'(ae0), 32'd1);
        check("rst_af", 32'(af0), 32'd0);
        check("rst_dout", 32'(dout0), 32'd0);
        check("rst_ov", 32'(ov0), 32'd0);
        check("rst_un", 32'(un0), 32'd0);
        check("rst1_count", 32'(count1), 32'd0);
        rst0 = 1'b0;
        rst1 = 1'b0;
        tick();

        // ---------------- vector table for instance 0 ----------------
        for (int i = 0; i < 16; i++) add(1, 0, 0, 16'(i), i + 1, 16'h0000, 0, 0);
        add(1, 0, 0, 16'hAAAA, 16, 16'h0000, 1, 0);                 // rejected push
        for (int j = 0; j < 16; j++) add(0, 1, 0, 16'h0, 15 - j, 16'(j), 1, 0);
        add(0, 1, 0, 16'h0, 0, 16'd15, 1, 1);                       // pop on empty
        add(0, 0, 1, 16'h0, 0, 16'd15, 0, 0);                       // clear both
        add(0, 1, 1, 16'h0, 0, 16'd15, 0, 1);                       // set beats clear
        add(0, 0, 1, 16'h0, 0, 16'd15, 0, 0);
        add(1, 1, 0, 16'h0077, 1, 16'd15, 0, 1);                    // push+pop on empty
        add(0, 0, 1, 16'h0, 1, 16'd15, 0, 0);
        add(0, 1, 0, 16'h0, 0, 16'h0077, 0, 0);
        for (int i = 0; i < 16; i++) add(1, 0, 0, 16'(100 + i), i + 1, 16'h0077, 0, 0);
        add(1, 1, 0, 16'h0055, 16, 16'd100, 0, 0);                  // push+pop at full
        for (int j = 1; j < 16; j++) add(0, 1, 0, 16'h0, 16 - j, 16'(100 + j), 0, 0);
        add(0, 1, 0, 16'h0, 0, 16'h0055, 0, 0);

        for (int k = 0; k < vq.size(); k++) begin
            push0 = vq[k].push;
            pop0  = vq[k].pop;
            clr0  = vq[k].clr;
            din0  = vq[k].din;
            tick();
            check($sformatf("v%0d_count", k), 32'(count0), 32'(vq[k].cnt));
            check($sformatf("v%0d_dout", k), 32'(dout0), 32'(vq[k].dout));
            check($sformatf("v%0d_full", k), 32'(full0), 32'(vq[k].cnt == 16));
            check($sformatf("v%0d_pndng", k), 32'(pndng0), 32'(vq[k].cnt != 0));
            check($sformatf("v%0d_af", k), 32'(af0), 32'(vq[k].cnt >= 14));
            check($sformatf("v%0d_ae", k), 32'(ae0), 32'(vq[k].cnt <= 2));
            check($sformatf("v%0d_ov", k), 32'(ov0), 32'(vq[k].ov));
            check($sformatf("v%0d_un", k), 32'(un0), 32'(vq[k].un));
        end
        push0 = 1'b0;
        pop0  = 1'b0;
        clr0  = 1'b0;

        // ---------------- async reset mid-stream ----------------
        for (int i = 0; i < 10; i++) begin
            push0 = 1'b1;
            din0  = 16'(200 + i);
            tick();
        end
        push0 = 1'b0;
        pop0  = 1'b1;
        tick();
        pop0  = 1'b0;
        check("pre_rst_count", 32'(count0), 32'd9);
        check("pre_rst_dout", 32'(dout0), 32'd200);
        @(negedge clk);
        rst0 = 1'b1;
        #1;
        check("async_rst_count", 32'(count0), 32'd0);
        check("async_rst_pndng", 32'(pndng0), 32'd0);
        check("async_rst_dout", 32'(dout0), 32'd0);
        check("async_rst_ae", 32'(ae0), 32'd1);
        #2;
        rst0 = 1'b0;
        tick();
        push0 = 1'b1;
        din0  = 16'h1234;
        tick();
        push0 = 1'b0;
        pop0  = 1'b1;
        tick();
        pop0  = 1'b0;
        check("post_rst_dout", 32'(dout0), 32'h1234);
        check("post_rst_count", 32'(count0), 32'd0);

        // ---------------- fall-through, DEPTH 5 ----------------
        m_ov   = 1'b0;
        m_un   = 1'b0;
        pushes = 0;
        nxt    = 16'h0300;
        for (int k = 0; k < 30; k++) begin
            pu = (pushes < 12) && (k % 3 != 2);
            po = (k % 2 == 1) || (k >= 20);
            if (mq.size() != 0)
                check($sformatf("fwft%0d_head", k), 32'(dout1), 32'(mq[0]));
            push1 = pu;
            pop1  = po;
            din1  = nxt;
            p_ok = po && (mq.size() != 0);
            w_ok = pu && ((mq.size() < 5) || p_ok);
            if (pu && !w_ok) m_ov = 1'b1;
            if (po && !p_ok) m_un = 1'b1;
            if (p_ok) void'(mq.pop_front());
            if (w_ok) mq.push_back(nxt);
            if (pu) begin
                pushes++;
                nxt = nxt + 16'd1;
            end
            tick();
            check($sformatf("fwft%0d_count", k), 32'(count1), 32'(mq.size()));
            check($sformatf("fwft%0d_full", k), 32'(full1), 32'(mq.size() == 5));
            check($sformatf("fwft%0d_ov", k), 32'(ov1), 32'(m_ov));
            check($sformatf("fwft%0d_un", k), 32'(un1), 32'(m_un));
        end
        push1 = 1'b0;
        pop1  = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
